// File: rtl/frame_sequencer_pkg.sv
// Shared types and helpers for the frame sequencer block.
package frame_seq_pkg;

  localparam int ANIM_W  = 5;
  localparam int FRAME_W = 5;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } seq_state_t;

  // Frame count of an animation at 6 bits; a limit of 0 stands for 32 frames.
  function automatic logic [FRAME_W:0] eff_limit(input logic [FRAME_W-1:0] limit);
    return (limit == '0) ? 6'd32 : {1'b0, limit};
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control inputs and frame outputs of the frame sequencer, plus its FSM state.
// The signals are plain levels and pulses; no valid/ready handshake is involved.
interface frame_sequencer_if;
  import frame_seq_pkg::*;

  logic               ena;
  logic [ANIM_W-1:0]  animation;
  logic [FRAME_W-1:0] limit;
  logic [2:0]         speed;
  logic               pause;
  logic               step;
  logic [FRAME_W-1:0] frame;
  logic               frame_tick;
  logic               wrap;
  logic               restart;
  seq_state_t         state;

  modport master (
    output ena, animation, limit, speed, pause, step,
    input  frame, frame_tick, wrap, restart, state
  );

  modport slave (
    input  ena, animation, limit, speed, pause, step,
    output frame, frame_tick, wrap, restart, state
  );
endinterface

// File: rtl/frame_sequencer_tick_prescaler.sv
// Rate prescaler: emits one tick every (BASE_DIV >> speed) enabled cycles.
module tick_prescaler #(
  parameter int BASE_DIV = 2**20,
  parameter int DIV_W    = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       clr,
  input  logic [2:0] speed,
  output logic       tick
);

  localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic [DIV_W-1:0] period_m1;

  assign period_m1 = (BASE >> speed) - DIV_W'(1);

  // A count above the period (after a speed increase) restarts silently.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (ena) begin
      if (clr) begin
        count_d = '0;
      end else if (count_q == period_m1) begin
        count_d = '0;
        tick    = 1'b1;
      end else if (count_q > period_m1) begin
        count_d = '0;
      end else begin
        count_d = count_q + DIV_W'(1);
      end
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: steps, wraps and restarts the frame index of the selected animation.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int BASE_DIV = 2**20,
  parameter int DIV_W    = 21
) (
  input logic               clk,
  input logic               rst,
  frame_sequencer_if.slave  bus
);

  seq_state_t         state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [ANIM_W-1:0]  anim_q;
  logic               step_q;
  logic               frame_tick_q;
  logic               wrap_q;
  logic               restart_q;

  logic               tick;
  logic               anim_change;
  logic               out_of_range;
  logic               advance;
  logic [FRAME_W:0]   lim;
  logic [FRAME_W:0]   inc;
  logic [FRAME_W-1:0] next_frame;

  assign lim          = eff_limit(bus.limit);
  assign inc          = {1'b0, frame_q} + 6'd1;
  assign next_frame   = (inc == lim) ? '0 : inc[FRAME_W-1:0];
  assign anim_change  = (bus.animation != anim_q);
  assign out_of_range = ({1'b0, frame_q} >= lim);
  // RUN advances on the prescaler tick, HOLD only on a rising edge of step.
  assign advance      = (state_q == RUN) ? tick : (bus.step & ~step_q);

  tick_prescaler #(
    .BASE_DIV (BASE_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .ena   (bus.ena),
    .clr   (anim_change | (state_q == HOLD)),
    .speed (bus.speed),
    .tick  (tick)
  );

  // Sequencer FSM, frame register and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      frame_q      <= '0;
      anim_q       <= '0;
      step_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      wrap_q       <= 1'b0;
      restart_q    <= 1'b0;
    end else if (!bus.ena) begin
      frame_tick_q <= 1'b0;
      wrap_q       <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      step_q       <= bus.step;
      frame_tick_q <= 1'b0;
      wrap_q       <= 1'b0;
      restart_q    <= 1'b0;
      case (state_q)
        RUN:     if (bus.pause)  state_q <= HOLD;
        HOLD:    if (!bus.pause) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (anim_change) begin
        frame_q   <= '0;
        anim_q    <= bus.animation;
        restart_q <= 1'b1;
      end else if (out_of_range) begin
        frame_q <= '0;
      end else if (advance) begin
        frame_q      <= next_frame;
        frame_tick_q <= 1'b1;
        wrap_q       <= (next_frame == '0);
      end
    end
  end

  assign bus.frame      = frame_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.wrap       = wrap_q;
  assign bus.restart    = restart_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a 16-cycle base frame period.
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  frame_sequencer_if sif ();

  frame_sequencer #(
    .BASE_DIV (16),
    .DIV_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle before sampling or driving.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run until frame_tick is seen or the budget expires; returns edges taken.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (sif.frame_tick !== 1'b1 && n < max);
  endtask

  initial begin
    int n;
    int bad;
    tests = 0;
    fails = 0;

    // ---- Test 1: speed 0, limit 10 ----
    rst = 1'b1;
    sif.ena = 1'b1; sif.animation = 5'd0; sif.limit = 5'd10;
    sif.speed = 3'd0; sif.pause = 1'b0; sif.step = 1'b0;
    cyc(2);
    chk("reset_frame", sif.frame, 0);
    chk("reset_tick", sif.frame_tick, 0);
    chk("reset_wrap", sif.wrap, 0);
    chk("reset_restart", sif.restart, 0);
    chk("reset_state", 32'(sif.state), 32'(RUN));
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wait_tick(40, n);
      chk("t1_period", n, 16);
      chk("t1_frame", sif.frame, i % 10);
      chk("t1_wrap", sif.wrap, (i == 10) ? 1 : 0);
    end
    for (int i = 1; i <= 3; i++) wait_tick(40, n);
    chk("t1_frame3", sif.frame, 3);
    cyc(15);
    rst = 1'b1;                      // next edge would have been a tick
    sif.limit = 5'd0; sif.speed = 3'd3;
    cyc(1);
    chk("t1_rst_frame", sif.frame, 0);
    chk("t1_rst_tick", sif.frame_tick, 0);
    chk("t1_rst_wrap", sif.wrap, 0);

    // ---- Test 2: 32 frames, period 2 ----
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      wait_tick(10, n);
      chk("t2_period", n, 2);
      chk("t2_frame", sif.frame, i % 32);
      chk("t2_wrap", sif.wrap, (i == 32) ? 1 : 0);
    end

    // ---- Test 3: single-frame animation ----
    sif.limit = 5'd1;
    for (int i = 1; i <= 4; i++) begin
      wait_tick(10, n);
      chk("t3_period", n, 2);
      chk("t3_frame", sif.frame, 0);
      chk("t3_wrap", sif.wrap, 1);
    end

    // ---- Test 4: animation change coinciding with a tick ----
    rst = 1'b1;
    sif.animation = 5'd1; sif.limit = 5'd10; sif.speed = 3'd0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("t4_first_restart", sif.restart, 1);
    for (int i = 1; i <= 7; i++) begin
      wait_tick(40, n);
      chk("t4_period", n, 16);
    end
    chk("t4_frame7", sif.frame, 7);
    cyc(15);
    sif.animation = 5'd2;
    cyc(1);
    chk("t4_restart", sif.restart, 1);
    chk("t4_frame", sif.frame, 0);
    chk("t4_tick", sif.frame_tick, 0);
    chk("t4_wrap", sif.wrap, 0);
    wait_tick(40, n);
    chk("t4_next_period", n, 16);
    chk("t4_next_frame", sif.frame, 1);

    // ---- Test 5: pause and step ----
    wait_tick(40, n);
    wait_tick(40, n);
    chk("t5_frame3", sif.frame, 3);
    sif.pause = 1'b1;
    cyc(1);
    chk("t5_state", 32'(sif.state), 32'(HOLD));
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      cyc(1);
      if (sif.frame !== 5'd3 || sif.frame_tick !== 1'b0) bad++;
    end
    chk("t5_hold_quiet", bad, 0);
    for (int i = 4; i <= 6; i++) begin
      sif.step = 1'b1;
      cyc(1);
      chk("t5_step_frame", sif.frame, i);
      chk("t5_step_tick", sif.frame_tick, 1);
      sif.step = 1'b0;
      cyc(1);
      chk("t5_step_low", sif.frame_tick, 0);
    end
    sif.step = 1'b1;
    cyc(1);
    chk("t5_held_first", sif.frame, 7);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (sif.frame !== 5'd7 || sif.frame_tick !== 1'b0) bad++;
    end
    chk("t5_held_once", bad, 0);
    sif.step = 1'b0;
    sif.pause = 1'b0;
    cyc(1);
    chk("t5_run", 32'(sif.state), 32'(RUN));
    wait_tick(40, n);
    chk("t5_resume_period", n, 16);
    chk("t5_resume_frame", sif.frame, 8);

    // ---- Test 6: limit shrink, then ena low ----
    sif.limit = 5'd12;
    wait_tick(40, n);
    chk("t6_frame9", sif.frame, 9);
    sif.limit = 5'd6;
    cyc(1);
    chk("t6_oor_frame", sif.frame, 0);
    chk("t6_oor_tick", sif.frame_tick, 0);
    chk("t6_oor_wrap", sif.wrap, 0);
    chk("t6_oor_restart", sif.restart, 0);
    sif.ena = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (sif.frame !== 5'd0 || sif.frame_tick !== 1'b0 ||
          sif.wrap !== 1'b0 || sif.restart !== 1'b0) bad++;
    end
    chk("t6_frozen", bad, 0);
    sif.ena = 1'b1;
    wait_tick(40, n);
    chk("t6_prescaler_kept", n, 15);
    chk("t6_frame1", sif.frame, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Drives the per-animation frame index for the 7-segment animation engine.
- Sits directly downstream of the animation length lookup. It takes the currently selected animation and that animation's frame count, `limit`.
- Steps a frame counter at a programmable rate, wraps it at the limit, and restarts it whenever the animation selection changes.
- Its `frame` output feeds the segment-pattern ROM stage.

Parameters:
- BASE_DIV, 2**20, clock cycles per frame at speed 0. Must be a power of two and ≥ 128.
- DIV_W, 21, prescaler counter width. Must satisfy 2**DIV_W > BASE_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  global enable; when low, all state freezes
- animation  in  5  selected animation number
- limit  in  5  frames in the current animation; 0 encodes 32
- speed  in  3  rate select; frame period = BASE_DIV >> speed cycles
- pause  in  1  level; holds the current frame
- step  in  1  level; each rising edge while paused advances one frame
- frame  out  5  current frame index, 0..limit-1
- frame_tick  out  1  one-cycle pulse in the cycle `frame` updates by advance
- wrap  out  1  one-cycle pulse when an advance returns `frame` to 0
- restart  out  1  one-cycle pulse when a change of `animation` resets `frame`

Behaviour:
- Reset:
  - frame, frame_tick, wrap, restart = 0.
  - Prescaler = 0; anim_q = 0; step_q = 0; FSM = RUN.
  - Takes effect at the next clk edge, mid-animation included.
- ena = 0:
  - No register changes, including prescaler, anim_q, step_q and FSM.
  - frame holds its value; all pulse outputs are 0.
- Effective limit: L = (limit == 0) ? 32 : limit, evaluated at 6 bits.
  - Next frame = (frame + 1 == L) ? 0 : frame + 1, computed at 6 bits and truncated to 5.
- Prescaler:
  - Counts 0..P-1, where P = BASE_DIV >> speed.
  - tick is asserted in the cycle the count equals P-1; the count then returns to 0.
  - If speed changes so that count > P-1, the count resets to 0 on the next cycle with no tick.
- FSM states: RUN, HOLD.
  - RUN → HOLD when pause = 1. HOLD → RUN when pause = 0. Transitions are registered.
  - RUN: advance on tick.
  - HOLD: prescaler is held at 0; advance when step = 1 and step_q = 0 (rising edge). step_q <= step every enabled cycle.
- Advance:
  - frame <= next frame; frame_tick = 1.
  - wrap = 1 if the next frame is 0.
  - All outputs are registered, so the pulses coincide with the new frame value.
- Priority, highest first, within one enabled cycle:
  1. Animation change (animation != anim_q):
     - frame <= 0, prescaler <= 0, anim_q <= animation, restart = 1.
     - No frame_tick or wrap that cycle, even if tick or a step edge coincides.
  2. Out-of-range (frame ≥ L, e.g. limit shrank without an animation change):
     - frame <= 0; no pulses.
  3. Advance, as above.
- Boundary cases:
  - L = 1: frame stays 0; every advance pulses both frame_tick and wrap.
  - L = 32: frame counts 0..31 and wraps 31 → 0.
- Pause and step interaction:
  - A step edge in RUN is ignored.
  - A pause asserted in the same cycle as a tick still advances, because the FSM is still in RUN.

Decomposition:
- Package frame_seq_pkg contains:
  - ANIM_W = 5, FRAME_W = 5
  - seq_state_t {RUN, HOLD}
  - function eff_limit(limit), mapping 0 → 32 at 6 bits
- Sub-module tick_prescaler:
  - Parameters: BASE_DIV, DIV_W.
  - Ports: clk, rst, ena, clr, speed → tick.
  - `clr` is driven by restart or HOLD.

Test Plan:
1. BASE_DIV = 16, speed = 0, limit = 10, animation held:
   - frame_tick every 16 cycles; frame goes 0→9.
   - wrap with frame = 0 on the 10th tick.
   - Reset mid-run: all outputs 0 on the next edge.
2. limit = 0 (32 frames), speed = 3 (period 2):
   - frame counts 0..31, then wrap with frame = 0.
3. limit = 1:
   - frame constant at 0; frame_tick and wrap both pulse on every tick.
4. Animation change 1 → 2 at frame = 7, coinciding with a tick:
   - restart = 1, frame = 0, frame_tick = 0.
   - Next tick arrives a full 16 cycles later.
5. Pause at frame = 3:
   - No advance for ≥ 100 cycles.
   - Three step pulses give frames 4, 5, 6, each with frame_tick.
   - A step held high advances only once.
   - Unpause resumes ticking after 16 cycles.
6. At frame = 9, limit changes 12 → 6 without an animation change:
   - frame = 0 next cycle with no pulses.
   - ena = 0 for 50 cycles: frame and prescaler frozen, no pulses.
